// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus between a single master and a single slave.
// The master modport drives the address/data valids and payloads plus the
// response readies; the slave modport drives the opposite directions.
interface axil_cmd_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);

  // Write-address channel
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  // Write-data channel
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;

  // Write-response channel
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  // Read-address channel
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  // Read-data channel
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master.
// Accepts one command (read or write) on a valid/ready stream, runs the
// matching AXI-Lite transaction, and returns the captured response on a
// valid/ready response stream. Every output comes straight from a flop.
module axil_cmd_master #(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 16,
  parameter int         STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                  clk,
  input  logic                  rst,

  // Command stream
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,

  // Response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,

  // AXI4-Lite master port
  axil_cmd_master_if.master     axil
);

  typedef enum logic [2:0] {
    IDLE,
    WR_AW,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  arvalid_q;
  logic                  rready_q;

  // The latched command is the AXI payload; both address channels share it.
  assign axil.awaddr  = addr_q;
  assign axil.awprot  = PROT;
  assign axil.awvalid = awvalid_q;
  assign axil.wdata   = wdata_q;
  assign axil.wstrb   = wstrb_q;
  assign axil.wvalid  = wvalid_q;
  assign axil.bready  = bready_q;
  assign axil.araddr  = addr_q;
  assign axil.arprot  = PROT;
  assign axil.arvalid = arvalid_q;
  assign axil.rready  = rready_q;

  // Transaction sequencer: command accept, AXI channel handshakes, response hand-off.
  // NOTE: the reset is asynchronous so a mid-transaction rst drops every valid
  // immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads
      // the values the flops held before this edge.
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            if (cmd_write) begin
              wdata_q   <= cmd_wdata;
              wstrb_q   <= cmd_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WR_AW;
            end else begin
              arvalid_q <= 1'b1;
              state     <= RD_AR;
            end
          end else begin
            // First edge out of reset raises cmd_ready here.
            cmd_ready <= 1'b1;
          end
        end

        WR_AW: begin
          // AW and W complete independently; a valid that is already low
          // counts as done.
          if (axil.awready) awvalid_q <= 1'b0;
          if (axil.wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || axil.awready) && (!wvalid_q || axil.wready)) begin
            bready_q <= 1'b1;
            state    <= WR_B;
          end
        end

        WR_B: begin
          if (axil.bvalid) begin
            rsp_resp  <= axil.bresp;
            rsp_rdata <= '0;
            bready_q  <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end

        RD_AR: begin
          if (axil.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_R;
          end
        end

        RD_R: begin
          // Data is captured whatever the response code says.
          if (axil.rvalid) begin
            rsp_rdata <= axil.rdata;
            rsp_resp  <= axil.rresp;
            rready_q  <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end

        RSP: begin
          // Raising cmd_ready together with the hand-off keeps the command
          // period at four cycles against a zero-wait slave.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Self-checking bench for axil_cmd_master.
// A behavioural AXI-Lite memory slave with stall/error knobs sits on the bus;
// a word-addressed reference memory predicts every response.
module tb_axil_cmd_master;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = DW / 8;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  axil_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) axil ();

  axil_cmd_master #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .STRB_WIDTH(SW),
    .PROT      (3'b000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .axil      (axil)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] byte_merge(logic [31:0] old, logic [31:0] nw, logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(logic [15:0] a);
    int k = int'(a >> 2);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    ref_mem[int'(a >> 2)] = byte_merge(ref_read(a), d, s);
  endtask

  // ---------------- behavioural slave ----------------
  int unsigned stall_pct   = 0;
  logic        aw_block    = 1'b0;
  logic        b_block     = 1'b0;
  logic        force_rd    = 1'b0;
  logic [31:0] force_rdata = 32'h0;
  logic [1:0]  force_rresp = 2'b00;
  logic [1:0]  force_bresp = 2'b00;

  bit   [31:0] smem [0:16383];
  logic        s_aw_have, s_w_have, s_ar_have;
  logic [15:0] s_awaddr, s_araddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        go_b, go_r;

  logic        aw_hs, w_hs, ar_hs, aw_now, w_now, ar_now;
  logic [15:0] wr_addr, rd_addr;
  logic [31:0] wr_data, wr_merged;
  logic [3:0]  wr_strb;

  assign aw_hs     = axil.awvalid && axil.awready;
  assign w_hs      = axil.wvalid && axil.wready;
  assign ar_hs     = axil.arvalid && axil.arready;
  assign aw_now    = s_aw_have || aw_hs;
  assign w_now     = s_w_have || w_hs;
  assign ar_now    = s_ar_have || ar_hs;
  assign wr_addr   = s_aw_have ? s_awaddr : axil.awaddr;
  assign wr_data   = s_w_have ? s_wdata : axil.wdata;
  assign wr_strb   = s_w_have ? s_wstrb : axil.wstrb;
  assign rd_addr   = s_ar_have ? s_araddr : axil.araddr;
  assign wr_merged = byte_merge(smem[wr_addr[15:2]], wr_data, wr_strb);

  // Memory slave: random ready stalls, response one cycle after the last handshake.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      axil.awready <= 1'b0;
      axil.wready  <= 1'b0;
      axil.arready <= 1'b0;
      axil.bvalid  <= 1'b0;
      axil.bresp   <= 2'b00;
      axil.rvalid  <= 1'b0;
      axil.rresp   <= 2'b00;
      axil.rdata   <= '0;
      s_aw_have    <= 1'b0;
      s_w_have     <= 1'b0;
      s_ar_have    <= 1'b0;
      s_awaddr     <= '0;
      s_araddr     <= '0;
      s_wdata      <= '0;
      s_wstrb      <= '0;
      go_b         <= 1'b0;
      go_r         <= 1'b0;
    end else begin
      axil.awready <= !aw_block && ((stall_pct == 0) || ($urandom_range(99) >= stall_pct));
      axil.wready  <= (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
      axil.arready <= (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
      go_b         <= !b_block && ((stall_pct == 0) || ($urandom_range(99) >= stall_pct));
      go_r         <= (stall_pct == 0) || ($urandom_range(99) >= stall_pct);

      if (aw_hs) begin
        s_aw_have <= 1'b1;
        s_awaddr  <= axil.awaddr;
      end
      if (w_hs) begin
        s_w_have <= 1'b1;
        s_wdata  <= axil.wdata;
        s_wstrb  <= axil.wstrb;
      end
      if (ar_hs) begin
        s_ar_have <= 1'b1;
        s_araddr  <= axil.araddr;
      end

      if (axil.bvalid && axil.bready) axil.bvalid <= 1'b0;
      if (axil.rvalid && axil.rready) axil.rvalid <= 1'b0;

      if (aw_now && w_now && !axil.bvalid && go_b) begin
        smem[wr_addr[15:2]] <= wr_merged;
        s_aw_have   <= 1'b0;
        s_w_have    <= 1'b0;
        axil.bvalid <= 1'b1;
        axil.bresp  <= force_bresp;
      end
      if (ar_now && !axil.rvalid && go_r) begin
        s_ar_have   <= 1'b0;
        axil.rvalid <= 1'b1;
        axil.rdata  <= force_rd ? force_rdata : smem[rd_addr[15:2]];
        axil.rresp  <= force_rresp;
      end
    end
  end

  // ---------------- transaction task ----------------
  // Issues one command, checks busy behaviour, the response payload (held for
  // 'hold' extra cycles with rsp_ready low) and the return to idle.
  task automatic xact(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int hold, input logic [1:0] exp_resp,
                      input logic [31:0] exp_rdata, output int lat);
    int guard;
    lat = 0;
    @(negedge clk);
    rsp_ready = (hold == 0);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_accept_in_time", 64'(guard < 200), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = 16'($urandom);
    cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom);
    lat = 1;
    check("busy_cmd_ready", 64'(cmd_ready), 64'd0);
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_valid_in_time", 64'(rsp_valid), 64'd1);
    check("rsp_resp", 64'(rsp_resp), 64'(exp_resp));
    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_valid_cleared", 64'(rsp_valid), 64'd0);
    check("cmd_ready_after_rsp", 64'(cmd_ready), 64'd1);
  endtask

  // Bound on total run time; a hang still reports before stopping.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int          lat;
    int          guard;
    bit          wr;
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  s;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_valids", 64'({axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready, rsp_valid}), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_resp", 64'(rsp_resp), 64'd0);
    check("rst_awaddr", 64'(axil.awaddr), 64'd0);
    check("rst_wdata", 64'(axil.wdata), 64'd0);
    check("rst_wstrb", 64'(axil.wstrb), 64'd0);
    rst = 1'b0;
    #1;
    check("release_cmd_ready_low", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("release_cmd_ready_high", 64'(cmd_ready), 64'd1);
    check("awprot", 64'(axil.awprot), 64'd0);
    check("arprot", 64'(axil.arprot), 64'd0);

    // 1: full write then read back, zero-wait slave latency
    xact(1'b1, 16'h0040, 32'hDEADBEEF, 4'hF, 0, 2'b00, 32'h0, lat);
    check("wr_latency", 64'(lat), 64'd3);
    ref_write(16'h0040, 32'hDEADBEEF, 4'hF);
    xact(1'b0, 16'h0040, 32'h0, 4'h0, 0, 2'b00, 32'hDEADBEEF, lat);
    check("rd_latency", 64'(lat), 64'd3);

    // 2: partial-strobe write merges bytes
    xact(1'b1, 16'h0040, 32'h11223344, 4'h5, 0, 2'b00, 32'h0, lat);
    ref_write(16'h0040, 32'h11223344, 4'h5);
    xact(1'b0, 16'h0040, 32'h0, 4'h0, 0, 2'b00, 32'hDE22BE44, lat);

    // 3: AW stalled while W completes; unaligned address passes through
    @(negedge clk);
    aw_block  = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 16'h0202;
    cmd_wdata = 32'hCAFEF00D;
    cmd_wstrb = 4'hF;
    check("t3_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = 16'hFFFF;
    check("t3_awvalid_up", 64'(axil.awvalid), 64'd1);
    check("t3_wvalid_up", 64'(axil.wvalid), 64'd1);
    check("t3_wdata", 64'(axil.wdata), 64'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_awvalid_held", 64'(axil.awvalid), 64'd1);
      check("t3_awaddr_stable", 64'(axil.awaddr), 64'h0202);
      check("t3_wvalid_dropped", 64'(axil.wvalid), 64'd0);
      check("t3_no_rsp", 64'(rsp_valid), 64'd0);
    end
    aw_block = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("t3_rsp_valid", 64'(rsp_valid), 64'd1);
    check("t3_rsp_resp", 64'(rsp_resp), 64'd0);
    @(negedge clk);
    check("t3_cmd_ready_back", 64'(cmd_ready), 64'd1);
    ref_write(16'h0202, 32'hCAFEF00D, 4'hF);
    xact(1'b0, 16'h0200, 32'h0, 4'h0, 0, 2'b00, ref_read(16'h0200), lat);

    // 4: read response held off by rsp_ready for 5 cycles
    xact(1'b0, 16'h0040, 32'h0, 4'h0, 5, 2'b00, ref_read(16'h0040), lat);

    // 6: error responses pass through unchanged
    force_rd    = 1'b1;
    force_rdata = 32'hA5A5A5A5;
    force_rresp = 2'b10;
    xact(1'b0, 16'h0040, 32'h0, 4'h0, 0, 2'b10, 32'hA5A5A5A5, lat);
    force_rd    = 1'b0;
    force_rresp = 2'b00;
    force_bresp = 2'b11;
    xact(1'b1, 16'h0300, 32'h0BADF00D, 4'hF, 0, 2'b11, 32'h0, lat);
    ref_write(16'h0300, 32'h0BADF00D, 4'hF);
    force_bresp = 2'b00;

    // 5: reset while waiting in WR_B
    @(negedge clk);
    b_block   = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 16'h0000;
    cmd_wdata = 32'h12345678;
    cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (!axil.bready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("t5_in_wr_b", 64'(axil.bready), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_valids_async", 64'({axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready, rsp_valid}), 64'd0);
    check("t5_cmd_ready_async", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("t5_cmd_ready_in_rst", 64'(cmd_ready), 64'd0);
    check("t5_valids_in_rst", 64'({axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready, rsp_valid}), 64'd0);
    rst     = 1'b0;
    b_block = 1'b0;
    #1;
    check("t5_cmd_ready_release", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("t5_cmd_ready_one_edge", 64'(cmd_ready), 64'd1);
    xact(1'b0, 16'h0000, 32'h0, 4'h0, 0, 2'b00, ref_read(16'h0000), lat);

    // Random traffic against a stalling slave
    stall_pct = 35;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(1));
      a  = 16'h0100 + 16'($urandom_range(63) << 2);
      d  = $urandom;
      s  = 4'($urandom_range(15));
      if (wr) begin
        xact(1'b1, a, d, s, int'($urandom_range(2)), 2'b00, 32'h0, lat);
        ref_write(a, d, s);
      end else begin
        xact(1'b0, a, d, s, int'($urandom_range(2)), 2'b00, ref_read(a), lat);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
